// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Shared state encoding, parity modes and parity helper for the configurable UART transmitter.
package uart_tx_fifo_cfg_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } tx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Widest supported frame; narrower words are zero-extended, which leaves the XOR unchanged.
  localparam int MAX_BITS = 9;

  function automatic logic frame_parity(input logic [MAX_BITS-1:0] word, input logic mode);
    case (mode)
      PARITY_EVEN: return ^word;
      PARITY_ODD:  return ~^word;
      default:     return ^word;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the transmitter; writes while full are dropped.
module uart_tx_fifo_cfg_fifo #(
  parameter int N_BITS     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [N_BITS-1:0]             din,
  output logic [N_BITS-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [N_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers (wrapping at the power-of-two depth) and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter: frame FSM, shift register, tick/bit counters and per-frame config latches.
module uart_tx_fifo_cfg
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int N_TICKS    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_s_tick,
  input  logic                          i_valid,
  input  logic [N_BITS-1:0]             i_din,
  output logic                          o_ready,
  input  logic                          i_parity_en,
  input  logic                          i_parity_odd,
  input  logic                          i_stop2,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_tx_done_tick,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int S_W = $clog2(2*N_TICKS);
  localparam int N_W = $clog2(N_BITS);
  localparam logic [S_W-1:0] S_BIT_END   = S_W'(N_TICKS-1);
  localparam logic [S_W-1:0] S_STOP2_END = S_W'(2*N_TICKS-1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(N_BITS-1);

  tx_state_e         state_r;
  logic [S_W-1:0]    s_r;
  logic [N_W-1:0]    n_r;
  logic [N_BITS-1:0] shift_r;
  logic              parity_en_r;
  logic              stop2_r;
  logic              parity_bit_r;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              bit_end_s;
  logic              stop_end_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [N_BITS-1:0] head_s;

  uart_tx_fifo_cfg_fifo #(
    .N_BITS     (N_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (i_clock),
    .reset (i_reset),
    .push  (i_valid),
    .pop   (pop_s),
    .din   (i_din),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (o_fifo_count)
  );

  assign bit_end_s      = i_s_tick && (s_r == S_BIT_END);
  assign o_ready        = !full_s;
  assign o_tx           = tx_r;
  assign o_busy         = busy_r;
  assign o_tx_done_tick = done_r;

  // Stop-bit end and the pop that begins a frame, either from idle or straight out of STOP
  always_comb begin
    stop_end_s = 1'b0;
    if (state_r == STOP) begin
      stop_end_s = i_s_tick && (s_r == (stop2_r ? S_STOP2_END : S_BIT_END));
    end else begin
      stop_end_s = 1'b0;
    end
    pop_s = !empty_s && ((state_r == IDLE) || stop_end_s);
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r      <= IDLE;
      s_r          <= {S_W{1'b0}};
      n_r          <= {N_W{1'b0}};
      shift_r      <= {N_BITS{1'b0}};
      parity_en_r  <= 1'b0;
      stop2_r      <= 1'b0;
      parity_bit_r <= 1'b0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (pop_s) begin
      // Config is sampled only here, so mid-frame changes apply to the next word.
      shift_r      <= head_s;
      parity_en_r  <= i_parity_en;
      stop2_r      <= i_stop2;
      parity_bit_r <= frame_parity(MAX_BITS'(head_s), i_parity_odd);
      s_r          <= {S_W{1'b0}};
      n_r          <= {N_W{1'b0}};
      state_r      <= START;
      tx_r         <= 1'b0;
      busy_r       <= 1'b1;
      done_r       <= stop_end_s;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r   <= 1'b1;
          busy_r <= 1'b0;
        end
        START: begin
          if (bit_end_s) begin
            s_r     <= {S_W{1'b0}};
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end else if (i_s_tick) begin
            s_r <= s_r + S_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            s_r     <= {S_W{1'b0}};
            shift_r <= {1'b0, shift_r[N_BITS-1:1]};
            if (n_r == N_LAST) begin
              n_r     <= {N_W{1'b0}};
              state_r <= parity_en_r ? PARITY : STOP;
              tx_r    <= parity_en_r ? parity_bit_r : 1'b1;
            end else begin
              n_r  <= n_r + N_W'(1);
              tx_r <= shift_r[1];
            end
          end else if (i_s_tick) begin
            s_r <= s_r + S_W'(1);
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            s_r     <= {S_W{1'b0}};
            state_r <= STOP;
            tx_r    <= 1'b1;
          end else if (i_s_tick) begin
            s_r <= s_r + S_W'(1);
          end
        end
        STOP: begin
          if (stop_end_s) begin
            s_r     <= {S_W{1'b0}};
            state_r <= IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (i_s_tick) begin
            s_r <= s_r + S_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench: frame-level reference model (queue of words plus expected line waveform per frame).
module tb_uart_tx_fifo_cfg;

  localparam int N_BITS     = 8;
  localparam int N_TICKS    = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clock      = 1'b0;
  logic              reset      = 1'b1;
  logic              s_tick     = 1'b1;
  logic              valid      = 1'b0;
  logic [N_BITS-1:0] din        = 8'h00;
  logic              parity_en  = 1'b0;
  logic              parity_odd = 1'b0;
  logic              stop2      = 1'b0;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;
  logic [2:0]        fifo_count;

  always #5 clock = ~clock;

  uart_tx_fifo_cfg #(
    .N_BITS(N_BITS), .N_TICKS(N_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_s_tick(s_tick), .i_valid(valid), .i_din(din),
    .o_ready(ready), .i_parity_en(parity_en), .i_parity_odd(parity_odd), .i_stop2(stop2),
    .o_tx(tx), .o_busy(busy), .o_tx_done_tick(done), .o_fifo_count(fifo_count)
  );

  typedef struct {
    logic [N_BITS-1:0] word;
    logic              pe;
    logic              odd;
    logic              st2;
    logic              par;
    int                len;
  } vec_t;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [N_BITS-1:0] exp_q[$];
  logic              exp_wave [0:511];
  int                exp_len  = 0;
  int                idx      = 0;
  bit                collecting = 1'b0;
  bit                bad        = 1'b0;
  int                done_count = 0;
  int                last_len   = 0;
  int                last_start_cyc = 0;
  int                last_done_cyc  = 0;
  int                shadow_err = 0;
  logic              last_par   = 1'b0;
  logic [N_BITS-1:0] cur_word;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_bit(input logic b);
    for (int t = 0; t < N_TICKS; t++) begin
      exp_wave[exp_len] = b;
      exp_len++;
    end
  endtask

  // Expected line for one frame, using the config present on the pop edge
  task automatic build_wave(input logic [N_BITS-1:0] w);
    int ones;
    ones    = $countones(w);
    exp_len = 0;
    add_bit(1'b0);
    for (int i = 0; i < N_BITS; i++) add_bit(w[i]);
    if (parity_en) add_bit(parity_odd ? ((ones % 2) == 0) : ((ones % 2) == 1));
    add_bit(1'b1);
    if (stop2) add_bit(1'b1);
  endtask

  task automatic monitor();
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
      check("done_in_frame", int'(collecting), 1);
      check("frame_wave", int'(bad), 0);
      check("frame_len", idx, exp_len);
      last_len   = idx;
      collecting = 1'b0;
    end
    if (!collecting && tx == 1'b0) begin
      check("start_has_word", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) cur_word = exp_q.pop_front();
      else cur_word = 8'h00;
      build_wave(cur_word);
      idx            = 0;
      bad            = 1'b0;
      collecting     = 1'b1;
      last_start_cyc = cyc;
    end
    if (collecting) begin
      if (idx >= exp_len) bad = 1'b1;
      else if (tx !== exp_wave[idx]) bad = 1'b1;
      if (idx == (1 + N_BITS) * N_TICKS + N_TICKS / 2) last_par = tx;
      idx++;
    end
    if (busy !== collecting || int'(fifo_count) != exp_q.size() ||
        ready !== (exp_q.size() < FIFO_DEPTH)) shadow_err++;
  endtask

  // One clock: model the write, let the edge happen, then sample away from it
  task automatic step();
    if (valid && !reset && exp_q.size() < FIFO_DEPTH) exp_q.push_back(din);
    @(posedge clock);
    cyc++;
    #1;
    if (reset) begin
      exp_q.delete();
      collecting = 1'b0;
    end else begin
      monitor();
    end
  endtask

  task automatic write_word(input logic [N_BITS-1:0] w);
    valid = 1'b1;
    din   = w;
    step();
    valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((collecting || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", int'(collecting || exp_q.size() != 0), 0);
  endtask

  task automatic wait_done(input int budget);
    int d;
    int n;
    d = done_count;
    n = 0;
    while (done_count == d && n < budget) begin
      step();
      n++;
    end
    check("wait_done", int'(done_count != d), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   wc;
    int   d0;
    int   bs;
    int   l1;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 160};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 176};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 176};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 176};

    reset = 1'b1;
    step();
    step();
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(ready), 1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      parity_en  = vecs[i].pe;
      parity_odd = vecs[i].odd;
      stop2      = vecs[i].st2;
      write_word(vecs[i].word);
      wc = cyc;
      drain(400);
      check("vec_len", last_len, vecs[i].len);
      check("vec_start_latency", last_start_cyc - wc, 1);
      check("vec_done_at", last_done_cyc - last_start_cyc, vecs[i].len);
      if (vecs[i].pe) check("vec_parity", int'(last_par), int'(vecs[i].par));
      check("vec_idle_busy", int'(busy), 0);
    end

    // Burst of six: the sixth word hits a full FIFO and is dropped
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    d0 = done_count;
    bs = 0;
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      din   = N_BITS'(8'hA1 + i);
      step();
      if (i == 1) bs = last_start_cyc;
      if (i == 4) begin
        check("burst_ready", int'(ready), 0);
        check("burst_count", int'(fifo_count), 4);
      end
    end
    valid = 1'b0;
    drain(1200);
    check("burst_dones", done_count - d0, 5);
    check("burst_span", last_done_cyc - bs, 5 * 160);

    // Config flipped mid-frame applies to the following word only
    parity_en = 1'b0; stop2 = 1'b0; parity_odd = 1'b0;
    write_word(8'h3C);
    write_word(8'h5A);
    repeat (N_TICKS * 4) step();
    parity_en = 1'b1;
    stop2     = 1'b1;
    wait_done(400);
    l1 = last_len;
    drain(400);
    check("cfg_first_len", l1, 160);
    check("cfg_second_len", last_len, 192);

    // Reset during the fourth data bit
    parity_en = 1'b0; stop2 = 1'b0;
    write_word(8'h96);
    write_word(8'h11);
    repeat (N_TICKS + 3 * N_TICKS + 5) step();
    d0    = done_count;
    reset = 1'b1;
    step();
    check("midrst_tx", int'(tx), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_done", int'(done), 0);
    reset = 1'b0;
    step();
    check("midrst_idle_tx", int'(tx), 1);
    write_word(8'hC3);
    drain(400);
    check("midrst_frames", done_count - d0, 1);
    check("midrst_len", last_len, 160);

    // Randomised writes and per-cycle config changes against the frame model
    for (int i = 0; i < 400; i++) begin
      valid      = ($urandom_range(0, 5) == 0);
      din        = N_BITS'($urandom);
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      step();
    end
    valid = 1'b0;
    drain(2000);

    check("shadow_busy_count_ready", shadow_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
